// File: rtl/rmii_rx_framer.sv
// RMII 100 Mb/s receive framer: preamble/SFD detection, dibit-to-byte
// assembly with a one-byte look-ahead buffer so the last byte can carry
// eof, length/alignment checking and an optional FCS check.
// Build option: define RMII_RX_CRC_CHECK_EN to compile in the CRC-32 check;
// without it rx_crc_ok reads 1 at every eof.
module rmii_rx_framer #(
    parameter int MAX_FRAME_BYTES     = 1518,
    parameter int MIN_PREAMBLE_DIBITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  rxd,
    input  logic        crs_dv,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_crc_ok,
    output logic        rx_err,
    output logic [10:0] frame_len
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME_BYTES);
    localparam logic [4:0]  MIN_PRE  = 5'(MIN_PREAMBLE_DIBITS);
    localparam logic [10:0] MIN_LEN  = 11'd64;
    localparam logic [10:0] LEN_SAT  = 11'h7FF;

    state_t      state;
    logic [4:0]  pre_cnt;
    logic [1:0]  dib_cnt;
    logic [7:0]  shreg;
    logic [7:0]  buf_byte;
    logic        buf_full;
    logic        buf_sof;
    logic [10:0] byte_cnt;

    logic [7:0]  next_byte;
    logic        byte_done;
    logic [10:0] next_cnt;
    logic        crc_ok_now;

`ifdef RMII_RX_CRC_CHECK_EN
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    logic [31:0] crc;
    logic [31:0] crc_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // CRC of the register plus the byte completing this cycle; residue test on the register
    always_comb begin
        crc_next   = crc_byte(crc, next_byte);
        crc_ok_now = (crc == CRC_RESIDUE);
    end
`else
    // without the FCS check every frame is reported as CRC-good
    always_comb begin
        crc_ok_now = 1'b1;
    end
`endif

    // next shift-register value, byte completion and saturating byte count
    always_comb begin
        next_byte = {rxd, shreg[7:2]};
        byte_done = (dib_cnt == 2'd3);
        next_cnt  = (byte_cnt == LEN_SAT) ? byte_cnt : byte_cnt + 11'd1;
    end

    // framing state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            dib_cnt   <= '0;
            shreg     <= '0;
            buf_byte  <= '0;
            buf_full  <= 1'b0;
            buf_sof   <= 1'b0;
            byte_cnt  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_crc_ok <= 1'b0;
            rx_err    <= 1'b0;
            frame_len <= '0;
`ifdef RMII_RX_CRC_CHECK_EN
            crc       <= CRC_INIT;
`endif
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            case (state)
                IDLE: begin
                    if (crs_dv) begin
                        case (rxd)
                            2'b01: begin
                                state   <= PREAMBLE;
                                pre_cnt <= 5'd1;
                            end
                            2'b00: state <= IDLE;
                            default: state <= DROP;
                        endcase
                    end
                end
                PREAMBLE: begin
                    if (!crs_dv) begin
                        state <= IDLE;
                    end else begin
                        case (rxd)
                            2'b01: begin
                                if (pre_cnt != 5'd31) pre_cnt <= pre_cnt + 5'd1;
                            end
                            2'b11: begin
                                if (pre_cnt >= MIN_PRE) begin
                                    state    <= DATA;
                                    dib_cnt  <= '0;
                                    byte_cnt <= '0;
                                    buf_full <= 1'b0;
                                    buf_sof  <= 1'b0;
`ifdef RMII_RX_CRC_CHECK_EN
                                    crc      <= CRC_INIT;
`endif
                                end else begin
                                    state <= DROP;
                                end
                            end
                            default: state <= DROP;
                        endcase
                    end
                end
                DATA: begin
                    if (!crs_dv) begin
                        state <= IDLE;
                        // the held byte is the last one of the frame
                        if (buf_full) begin
                            rx_valid  <= 1'b1;
                            rx_sof    <= buf_sof;
                            rx_eof    <= 1'b1;
                            rx_data   <= buf_byte;
                            frame_len <= byte_cnt;
                            rx_crc_ok <= crc_ok_now;
                            rx_err    <= (byte_cnt < MIN_LEN) || (dib_cnt != 2'd0) || !crc_ok_now;
                        end
                    end else begin
                        shreg   <= next_byte;
                        dib_cnt <= dib_cnt + 2'd1;
                        if (byte_done) begin
                            byte_cnt <= next_cnt;
                            buf_byte <= next_byte;
                            buf_full <= 1'b1;
                            buf_sof  <= (byte_cnt == 11'd0);
`ifdef RMII_RX_CRC_CHECK_EN
                            crc      <= crc_next;
`endif
                            // a new byte arriving releases the held one
                            if (buf_full) begin
                                rx_valid  <= 1'b1;
                                rx_sof    <= buf_sof;
                                rx_data   <= buf_byte;
                                frame_len <= byte_cnt;
                                if (next_cnt == MAX_LEN + 11'd1) begin
                                    rx_eof    <= 1'b1;
                                    rx_err    <= 1'b1;
                                    rx_crc_ok <= crc_ok_now;
                                    state     <= DROP;
                                end
                            end
                        end
                    end
                end
                DROP: begin
                    if (!crs_dv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: frames are built as byte lists, the
// expected pulse stream is derived from the byte list and the framing rules,
// and a per-cycle compare process checks the DUT against that stream.
module tb_rmii_rx_framer;

    localparam int MAX = 1518;
    localparam int MINP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rxd;
    logic        crs_dv;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_crc_ok;
    logic        rx_err;
    logic [10:0] frame_len;

    rmii_rx_framer #(
        .MAX_FRAME_BYTES     (MAX),
        .MIN_PREAMBLE_DIBITS (MINP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .crs_dv    (crs_dv),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_sof    (rx_sof),
        .rx_eof    (rx_eof),
        .rx_crc_ok (rx_crc_ok),
        .rx_err    (rx_err),
        .frame_len (frame_len)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0]  data;
        logic        sof;
        logic        eof;
        logic [10:0] len;
        logic        ok;
        logic        err;
        logic        chk_ok;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  frm[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  last_data = 8'h00;
    logic [10:0] eof_len;
    logic        eof_err;
    logic        eof_ok;
    int          eof_seen = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // bit-serial reference CRC-32 over frm[0..n-1], final value inverted
    function automatic logic [31:0] crc32_of(input int n);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            b = frm[i];
            for (int j = 0; j < 8; j++) begin
                fb = b[j] ^ c[0];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic logic model_ok();
        int n;
        n = frm.size();
`ifdef RMII_RX_CRC_CHECK_EN
        if (n < 4) return 1'b0;
        return crc32_of(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
`else
        return 1'b1;
`endif
    endfunction

    // expected pulses for the frame in frm: lead 2 means a bad leading dibit
    task automatic expect_frame(input int npre, input int partial, input int lead);
        int   n;
        logic ok;
        logic err;
        n = frm.size();
        if (lead == 2 || npre < MINP || n == 0) return;
        if (n > MAX) begin
            for (int i = 0; i < MAX; i++)
                exp_q.push_back('{frm[i], i == 0, i == MAX - 1, 11'(MAX), 1'b0, 1'b1, 1'b0});
        end else begin
            ok  = model_ok();
            err = (n < 64) || (partial != 0) || !ok;
            for (int i = 0; i < n; i++)
                exp_q.push_back('{frm[i], i == 0, i == n - 1, 11'(n), ok, err, 1'b1});
        end
    endtask

    task automatic put(input logic dv, input logic [1:0] d);
        crs_dv = dv;
        rxd    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) put(1'b1, b[2*k +: 2]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) put(1'b0, 2'b00);
    endtask

    task automatic build(input int n_payload, input int start);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < n_payload; i++) frm.push_back(8'(start + i));
        c = crc32_of(frm.size());
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic send_frame(input string nm, input int npre, input int partial, input int lead,
                              input int exp_pulses);
        expect_frame(npre, partial, lead);
        check({nm, "_model_pulses"}, exp_q.size(), exp_pulses);
        eof_seen = 0;
        if (lead == 1) begin put(1'b1, 2'b00); put(1'b1, 2'b00); end
        if (lead == 2) put(1'b1, 2'b10);
        for (int k = 0; k < npre; k++) put(1'b1, 2'b01);
        put(1'b1, 2'b11);
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
        for (int k = 0; k < partial; k++) put(1'b1, 2'b10);
        idle(6);
        check({nm, "_drain"}, exp_q.size(), 0);
    endtask

    // per-cycle comparison of the DUT against the expected pulse stream
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=%0h required=none at %0t", rx_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", rx_data, e.data);
                check("rx_sof", rx_sof, e.sof);
                check("rx_eof", rx_eof, e.eof);
                if (e.eof) begin
                    check("frame_len", frame_len, e.len);
                    check("rx_err", rx_err, e.err);
                    if (e.chk_ok) check("rx_crc_ok", rx_crc_ok, e.ok);
                end
            end
            last_data = rx_data;
            if (rx_eof === 1'b1) begin
                eof_seen++;
                eof_len = frame_len;
                eof_err = rx_err;
                eof_ok  = rx_crc_ok;
            end
        end else if (rst_n === 1'b1) begin
            check("rx_data_hold", rx_data, last_data);
            check("strobe_idle", {rx_sof, rx_eof}, 2'b00);
        end
        if (rst_n !== 1'b1) last_data = 8'h00;
    end

    task automatic check_zero(input string nm);
        check({nm, "_rx_data"}, rx_data, 8'h00);
        check({nm, "_strobes"}, {rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err}, 5'b0);
        check({nm, "_frame_len"}, frame_len, 11'd0);
    endtask

    initial begin
        logic exp_bad_ok;
        logic exp_bad_err;
        logic [7:0] pin [9];
`ifdef RMII_RX_CRC_CHECK_EN
        exp_bad_ok  = 1'b0;
        exp_bad_err = 1'b1;
`else
        exp_bad_ok  = 1'b1;
        exp_bad_err = 1'b0;
`endif
        rst_n  = 1'b0;
        crs_dv = 1'b0;
        rxd    = 2'b00;
        @(posedge clk);
        #1;
        put(1'b0, 2'b00);
        check_zero("reset");
        rst_n = 1'b1;
        idle(3);

        // pin the reference CRC against the standard check value
        pin = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(pin[i]);
        check("model_crc_pin", crc32_of(9), 32'hCBF4_3926);

        // good minimum-length frame
        build(60, 0);
        send_frame("good64", 15, 0, 0, 64);
        check("good64_eofs", eof_seen, 1);
        check("good64_len", eof_len, 11'd64);
        check("good64_err", eof_err, 1'b0);
        check("good64_ok", eof_ok, 1'b1);

        // corrupted payload bit
        build(60, 0);
        frm[16] = frm[16] ^ 8'h01;
        send_frame("badcrc", 15, 0, 1, 64);
        check("badcrc_ok", eof_ok, exp_bad_ok);
        check("badcrc_err", eof_err, exp_bad_err);

        // runt
        build(36, 8'h40);
        send_frame("runt", 15, 0, 0, 40);
        check("runt_len", eof_len, 11'd40);
        check("runt_err", eof_err, 1'b1);

        // short preamble, then a good frame
        build(60, 0);
        send_frame("shortpre", 3, 0, 0, 0);
        check("shortpre_eofs", eof_seen, 0);
        build(60, 8'h80);
        send_frame("after_short", 8, 0, 0, 64);
        check("after_short_len", eof_len, 11'd64);
        check("after_short_err", eof_err, 1'b0);

        // bad leading dibit drops the whole burst
        build(60, 0);
        send_frame("badlead", 15, 0, 2, 0);
        check("badlead_eofs", eof_seen, 0);

        // trailing partial byte
        build(60, 8'h10);
        send_frame("partial", 15, 2, 0, 64);
        check("partial_len", eof_len, 11'd64);
        check("partial_err", eof_err, 1'b1);
        check("partial_ok", eof_ok, 1'b1);

        // reset during byte 20 with carrier still up
        build(60, 0);
        for (int i = 0; i < 19; i++)
            exp_q.push_back('{frm[i], i == 0, 1'b0, 11'(i + 1), 1'b0, 1'b0, 1'b0});
        eof_seen = 0;
        for (int k = 0; k < 15; k++) put(1'b1, 2'b01);
        put(1'b1, 2'b11);
        for (int i = 0; i < 20; i++) send_byte(frm[i]);
        rst_n = 1'b0;
        put(1'b1, 2'b00);
        check_zero("midreset");
        put(1'b1, 2'b01);
        rst_n = 1'b1;
        put(1'b1, 2'b01);
        put(1'b1, 2'b00);
        for (int i = 21; i < frm.size(); i++) send_byte(frm[i]);
        idle(6);
        check("midreset_drain", exp_q.size(), 0);
        check("midreset_eofs", eof_seen, 0);
        build(60, 8'h20);
        send_frame("after_reset", 15, 0, 0, 64);
        check("after_reset_len", eof_len, 11'd64);
        check("after_reset_err", eof_err, 1'b0);

        // exactly maximum length
        build(MAX - 4, 8'h05);
        send_frame("maxlen", 15, 0, 0, MAX);
        check("maxlen_len", eof_len, 11'd1518);
        check("maxlen_err", eof_err, 1'b0);

        // oversize
        frm.delete();
        for (int i = 0; i < 1600; i++) frm.push_back(8'(i * 7));
        send_frame("oversize", 15, 0, 0, 1518);
        check("oversize_eofs", eof_seen, 1);
        check("oversize_len", eof_len, 11'd1518);
        check("oversize_err", eof_err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rmii_rx_framer.md
RMII_RX_FRAMER -- requirements
Module: rmii_rx_framer

Interface
REQ-001 SHALL have parameter MAX_FRAME_BYTES, default 1518, max accepted frame length in bytes (DA..FCS inclusive).
REQ-002 SHALL have parameter MIN_PREAMBLE_DIBITS, default 8, minimum count of 2'b01 dibits required before the SFD dibit.
REQ-003 SHALL have port clk  input  1  50 MHz RMII reference clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rxd  input  2  RMII receive dibit; rxd[0] is the earlier bit on the wire.
REQ-006 SHALL have port crs_dv  input  1  RMII carrier-sense/data-valid.
REQ-007 SHALL have port rx_data  output  8  received byte, LSB first on the wire.
REQ-008 SHALL have port rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 SHALL have port rx_sof  output  1  high with rx_valid on the first byte after the SFD.
REQ-010 SHALL have port rx_eof  output  1  high with rx_valid on the last byte of a frame.
REQ-011 SHALL have port rx_crc_ok  output  1  FCS good; meaningful only when rx_eof=1.
REQ-012 SHALL have port rx_err  output  1  frame error; meaningful only when rx_eof=1.
REQ-013 SHALL have port frame_len  output  11  byte count including FCS; meaningful only when rx_eof=1.

Function
REQ-014 SHALL operate at 100 Mb/s only: one dibit sampled per clk while crs_dv=1.
REQ-015 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: crs_dv=1 and rxd=01 -> PREAMBLE (count=1); crs_dv=1 and rxd=00 -> stay; crs_dv=1 and rxd of 10 or 11 -> DROP.
REQ-017 PREAMBLE: rxd=01 increments count, saturating at 31; rxd=11 with count>=MIN_PREAMBLE_DIBITS -> DATA; rxd=11 with count<MIN_PREAMBLE_DIBITS, or rxd of 00 or 10 -> DROP; crs_dv=0 -> IDLE.
REQ-018 DATA: shift byte as {rxd, byte[7:2]}; a byte completes on every 4th dibit.
REQ-019 SHALL hold each completed byte in a one-byte buffer. It SHALL emit the buffered byte (rx_valid=1, rx_eof=0) in the cycle after the edge that completes the next byte.
REQ-020 When crs_dv=0 is sampled in DATA, the buffered byte SHALL be emitted next cycle with rx_eof=1; the state SHALL then go to IDLE.
REQ-021 If crs_dv drops with no completed byte, nothing SHALL be emitted; the state SHALL go to IDLE.
REQ-022 rx_err at eof SHALL be 1 if any of the following holds: frame_len<64; a partial byte (dibit count!=0) at crs_dv fall; rx_crc_ok=0.
REQ-023 When byte MAX_FRAME_BYTES+1 completes, the buffered byte SHALL be emitted with rx_eof=1 and rx_err=1; the state SHALL then go to DROP.
REQ-024 DROP: SHALL ignore all input until crs_dv=0, then go to IDLE; no rx_valid in DROP.
REQ-025 CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, over every completed byte including FCS. rx_crc_ok=1 iff the register equals 0xDEBB20E3 after the last byte.
REQ-026 frame_len SHALL count completed bytes and saturate at 2047.
REQ-027 rx_valid, rx_sof, rx_eof SHALL be single-cycle pulses; rx_data and frame_len SHALL hold their value between pulses.

Reset
REQ-028 On rst_n=0 at a clk edge: state=IDLE; rx_data=0, rx_valid=0, rx_sof=0, rx_eof=0, rx_crc_ok=0, rx_err=0, frame_len=0; counters cleared; CRC register=0xFFFFFFFF.
REQ-029 Reset mid-frame SHALL discard the frame with no eof. If crs_dv remains high after reset, REQ-016 SHALL apply, so a frame in progress goes to DROP.

Configuration
REQ-030 Macro RMII_RX_CRC_CHECK_EN defined: CRC logic per REQ-025 is compiled in.
REQ-031 Macro RMII_RX_CRC_CHECK_EN undefined: no CRC logic; rx_crc_ok=1 at every eof; rx_err comes only from length and alignment.

Verification
REQ-032 Preamble of 15x01, then 11, then bytes 0x00..0x3B plus correct FCS -> 64 rx_valid pulses; sof on 0x00; eof on the last FCS byte; rx_crc_ok=1, rx_err=0, frame_len=64.
REQ-033 Same frame with bit 0 of byte 0x10 flipped -> 64 pulses; at eof rx_crc_ok=0, rx_err=1 (macro undefined: rx_crc_ok=1, rx_err=0).
REQ-034 Runt of 40 bytes with valid FCS -> 40 pulses; at eof frame_len=40, rx_err=1.
REQ-035 Only 3 preamble dibits before SFD, then 64 bytes -> zero rx_valid pulses; next good frame is received correctly.
REQ-036 rst_n=0 for 2 cycles during byte 20 while crs_dv stays 1 -> all outputs 0 the cycle after the reset edge; no eof for that frame; a following good frame is received with frame_len=64.
REQ-037 1600-byte frame -> eof with rx_err=1 and frame_len=1518 on the 1518th pulse; no further pulses until crs_dv falls.
